// File: rtl/bus_tx_flow_if.sv
// Bit/byte transmitter bus: controller requests and SCL edge pulses in,
// SDA drive value and transfer status out.
interface bus_tx_flow_if;
    // Request handshake: the master holds exactly one of req_byte_i/req_bit_i
    // high, with req_value_i stable, until tx_done_o pulses. req_value_i is
    // sampled only on acceptance (Idle or the done cycle). Dropping both
    // requests, or raising both, abandons the transfer in flight.
    logic       scl_negedge_i;
    logic       scl_posedge_i;
    logic       req_byte_i;
    logic       req_bit_i;
    logic [7:0] req_value_i;
    logic       sda_o;
    logic       tx_done_o;
    logic       tx_idle_o;
    logic       error_o;

    modport slave (
        input  scl_negedge_i,
        input  scl_posedge_i,
        input  req_byte_i,
        input  req_bit_i,
        input  req_value_i,
        output sda_o,
        output tx_done_o,
        output tx_idle_o,
        output error_o
    );

    modport master (
        output scl_negedge_i,
        output scl_posedge_i,
        output req_byte_i,
        output req_bit_i,
        output req_value_i,
        input  sda_o,
        input  tx_done_o,
        input  tx_idle_o,
        input  error_o
    );
endinterface

// File: rtl/bus_tx_flow.sv
// I3C data-path transmitter: shifts a byte (MSB first) or a single bit onto
// SDA, changing SDA only a programmable hold time after each SCL fall.
module bus_tx_flow #(
    parameter int HoldCntW = 20
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [HoldCntW-1:0] t_hd_dat_i,
    bus_tx_flow_if.slave        bus,
    output logic [2:0]          dbg_state_o
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_HOLD       = 3'd1,
        ST_DRIVE      = 3'd2,
        ST_AWAIT_FALL = 3'd3,
        ST_NEXT_TASK  = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [7:0]          sreg_q, sreg_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [HoldCntW-1:0] hold_cnt_q, hold_cnt_d;
    logic                mode_bit_q, mode_bit_d;
    logic                sda_q, sda_d;

    logic one_req;
    logic any_req;
    logic abort;
    logic drive_bit;
    logic take_edge;
    logic load;

    assign one_req   = bus.req_byte_i ^ bus.req_bit_i;
    assign any_req   = bus.req_byte_i | bus.req_bit_i;
    assign abort     = (state_q != ST_IDLE) && (!any_req || bus.error_o);
    assign drive_bit = mode_bit_q ? sreg_q[0] : sreg_q[7];

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        bit_cnt_d  = bit_cnt_q;
        hold_cnt_d = hold_cnt_q;
        mode_bit_d = mode_bit_q;
        sda_d      = sda_q;
        take_edge  = 1'b0;
        load       = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (one_req) begin
                        load       = 1'b1;
                        hold_cnt_d = t_hd_dat_i;
                        state_d    = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // An SCL rise before the hold expires forces the bit out now.
                    if (bus.scl_posedge_i || (hold_cnt_q == '0)) begin
                        sda_d     = drive_bit;
                        take_edge = bus.scl_posedge_i;
                        state_d   = ST_DRIVE;
                    end else begin
                        hold_cnt_d = hold_cnt_q - HoldCntW'(1);
                    end
                end
                ST_DRIVE: begin
                    take_edge = bus.scl_posedge_i;
                end
                ST_AWAIT_FALL: begin
                    if (bus.scl_negedge_i) begin
                        hold_cnt_d = t_hd_dat_i;
                        state_d    = ST_HOLD;
                    end
                end
                ST_NEXT_TASK: begin
                    if (one_req) begin
                        load    = 1'b1;
                        state_d = ST_AWAIT_FALL;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (take_edge) begin
                if (bit_cnt_q == 3'd0) begin
                    state_d = ST_NEXT_TASK;
                end else begin
                    bit_cnt_d = bit_cnt_q - 3'd1;
                    sreg_d    = {sreg_q[6:0], 1'b0};
                    state_d   = ST_AWAIT_FALL;
                end
            end

            if (load) begin
                sreg_d     = bus.req_value_i;
                mode_bit_d = bus.req_bit_i;
                bit_cnt_d  = bus.req_bit_i ? 3'd0 : 3'd7;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            sreg_q     <= '0;
            bit_cnt_q  <= '0;
            hold_cnt_q <= '0;
            mode_bit_q <= 1'b0;
            sda_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            bit_cnt_q  <= bit_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            mode_bit_q <= mode_bit_d;
            sda_q      <= sda_d;
        end
    end

    assign bus.sda_o     = sda_q;
    assign bus.tx_done_o = (state_q == ST_NEXT_TASK);
    assign bus.tx_idle_o = (state_q == ST_IDLE);
    assign bus.error_o   = bus.req_byte_i & bus.req_bit_i;
    assign dbg_state_o   = state_q;

endmodule

// File: doc/bus_tx_flow.md
# bus_tx_flow

Bit/byte transmitter for the I3C controller data path, the drive-side counterpart of the bit/byte receiver. On request from the controller flow FSM it serializes one byte (MSB first) or a single bit (T-bit, ACK/NACK) onto `sda_o`. Each new bit changes only while SCL is low, after a programmable data-hold delay following the SCL falling edge. A bit counts as sent at the SCL rising edge that samples it.

## Interface
Parameters:
- `HoldCntW`, default 20: width of the data-hold counter and `t_hd_dat_i`.

Ports:
- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  reset; asynchronous assert, active-low.
- `t_hd_dat_i`  in  HoldCntW  number of cycles SDA is held after the SCL fall before it changes. Quasi-static.
- `scl_negedge_i`  in  1  one-cycle pulse on the synchronized SCL falling edge.
- `scl_posedge_i`  in  1  one-cycle pulse on the synchronized SCL rising edge.
- `req_byte_i`  in  1  level request: transmit the byte `req_value_i[7:0]`.
- `req_bit_i`  in  1  level request: transmit the single bit `req_value_i[0]`.
- `req_value_i`  in  8  data to transmit. Sampled only on acceptance.
- `sda_o`  out  1  SDA drive value (registered).
- `tx_done_o`  out  1  one-cycle pulse: the requested bit or byte has been sent.
- `tx_idle_o`  out  1  high while in Idle.
- `error_o`  out  1  combinational `req_byte_i & req_bit_i`.

## Operation
- Registers:
  - 8-bit shift register `sreg`.
  - 3-bit `bit_cnt`.
  - HoldCntW `hold_cnt`.
  - latched mode (byte/bit).
- FSM states: Idle, Hold, Drive, AwaitFall, NextTaskDecision.
- **Idle**
  - `tx_idle_o`=1.
  - Exactly one request high → latch `req_value_i` into `sreg`.
  - `bit_cnt` = 7 for a byte, 0 for a bit.
  - `hold_cnt` = `t_hd_dat_i`.
  - → Hold.
  - Caller guarantees SCL is low when it first requests.
- **Hold**
  - `hold_cnt` decrements each cycle.
  - In the cycle `hold_cnt`==0: `sda_o` <= `sreg[7]` (byte) or `sreg[0]` (bit) → Drive.
- **Drive**
  - Wait for `scl_posedge_i`.
  - On the edge with `bit_cnt`==0 → NextTaskDecision.
  - On the edge with `bit_cnt`!=0: `bit_cnt`--, `sreg` <<= 1 → AwaitFall.
- **AwaitFall**
  - On `scl_negedge_i`: `hold_cnt` = `t_hd_dat_i` → Hold.
- **NextTaskDecision** (one cycle)
  - `tx_done_o`=1.
  - If exactly one request is high: latch `req_value_i` and mode, reload `bit_cnt` → AwaitFall. This gives back-to-back transfers with no gap.
  - Otherwise → Idle.
- `sda_o` changes only in the Hold→Drive transition and never in Idle. It holds its last driven value until the next drive. START/STOP/release belong to the upper layer.
- Abort: in any state other than Idle, if both requests are low or `error_o`=1 → Idle next cycle. Any pending done is discarded and `sda_o` is unchanged.
- The latched mode governs until done; a request type change mid-transfer is ignored unless it causes an abort.
- `scl_posedge_i` during Hold counts as a timing violation:
  - the bit is driven that same cycle;
  - the edge is processed as in Drive (sent/shift/done).
- `scl_negedge_i` outside AwaitFall is ignored.

## Timing
- Reset values:
  - state Idle, so `tx_idle_o`=1;
  - `sda_o`=1;
  - `tx_done_o`=0;
  - `sreg`, `bit_cnt`, `hold_cnt` = 0.
- Request accepted (edge k) → `sda_o` valid at edge k+`t_hd_dat_i`+2.
  - With `t_hd_dat_i`=0: accept at k, Hold at k+1, `sda_o` updated at k+2.
- Subsequent bits: `scl_negedge_i` at edge n → `sda_o` changes at edge n+`t_hd_dat_i`+2.
- `tx_done_o` is high in the cycle after the `scl_posedge_i` of the last bit (bit 0 of a byte, or the single bit).
- In the `tx_done_o` cycle, `req_*` and `req_value_i` are sampled for the next transfer.
- `error_o` is combinational with zero latency.

## Test plan
- **Byte transfer:** reset; `req_byte_i`=1, value 0xA5, `t_hd_dat_i`=3, SCL period 20 cycles.
  - `sda_o` sequence 1,0,1,0,0,1,0,1.
  - Each change occurs exactly 5 cycles after its negedge pulse.
  - One `tx_done_o` pulse after the 8th posedge.
- **Single bit:** `req_bit_i`=1, value 0x00.
  - `sda_o`=0 after `t_hd_dat_i`+2 cycles.
  - `tx_done_o` one cycle after the next posedge.
  - Then Idle with `tx_idle_o`=1 and `sda_o` still 0.
- **Back-to-back:** 0x3C followed by T-bit=1 with `req_bit_i` asserted in the done cycle.
  - 9 bits driven with no Idle cycle in between.
  - Two `tx_done_o` pulses.
- **Abort:** drop `req_byte_i` after 3 bits.
  - Idle next cycle, no `tx_done_o`, `sda_o` frozen.
  - A new request restarts at the MSB.
- **Error:** `req_byte_i`=`req_bit_i`=1 mid-transfer.
  - `error_o`=1 in the same cycle.
  - Idle next cycle.
- **Reset mid-byte:** assert `rst_ni` asynchronously.
  - `sda_o`=1, `tx_done_o`=0 and `tx_idle_o`=1 immediately, without waiting for a clock edge.
  - Hold-violation case: posedge arriving during Hold drives the bit in that cycle.
